// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle
interface fetch_unit_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemData;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemValid,
      input  imemData
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemValid,
      output imemData
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, single-outstanding imem fetch, IF/ID register
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            PcWrite,
   input  logic            IRWrite,
   input  logic            flush,
   input  logic            PcSrc,
   input  logic            Jmp,
   input  logic [31:0]     branchTarget,
   input  logic [31:0]     jmpTarget,
   fetch_unit_if.master    imem,
   output logic [31:0]     instrID,
   output logic [31:0]     pcPlus4ID,
   output logic            validID
);

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      WAIT    = 2'd1,
      HELD    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_buf_q, instr_buf_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic        if_valid_q, if_valid_d;

   logic        hold;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign hold     = ~PcWrite | ~IRWrite;
   assign target   = Jmp ? jmpTarget : (PcSrc ? branchTarget : pc_q);
   assign pc_plus4 = pc_q + 32'd4;

   // Gated by rstn so no request escapes while reset is asserted.
   assign imem.imemReq  = rstn & (state_q == REQ) & ~flush;
   assign imem.imemAddr = pc_q;

   assign instrID   = if_instr_q;
   assign pcPlus4ID = if_pc4_q;
   assign validID   = if_valid_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_buf_d = instr_buf_q;
      if_instr_d  = if_instr_q;
      if_pc4_d    = if_pc4_q;
      if_valid_d  = if_valid_q;

      unique case (state_q)
         REQ: begin
            if (flush) begin
               pc_d       = target;
               if_instr_d = NOP;
               if_pc4_d   = 32'd0;
               if_valid_d = 1'b0;
            end else begin
               state_d = WAIT;
               if (!hold) begin
                  if_instr_d = NOP;
                  if_pc4_d   = 32'd0;
                  if_valid_d = 1'b0;
               end
            end
         end
         WAIT: begin
            if (imem.imemValid) begin
               if (flush) begin
                  pc_d       = target;
                  if_instr_d = NOP;
                  if_pc4_d   = 32'd0;
                  if_valid_d = 1'b0;
                  state_d    = REQ;
               end else if (hold) begin
                  instr_buf_d = imem.imemData;
                  state_d     = HELD;
               end else begin
                  if_instr_d = imem.imemData;
                  if_pc4_d   = pc_plus4;
                  if_valid_d = 1'b1;
                  pc_d       = pc_plus4;
                  state_d    = REQ;
               end
            end else if (flush) begin
               // Response still in flight; it must be swallowed in DISCARD.
               pc_d       = target;
               if_instr_d = NOP;
               if_pc4_d   = 32'd0;
               if_valid_d = 1'b0;
               state_d    = DISCARD;
            end else if (!hold) begin
               if_instr_d = NOP;
               if_pc4_d   = 32'd0;
               if_valid_d = 1'b0;
            end
         end
         HELD: begin
            if (flush) begin
               pc_d       = target;
               if_instr_d = NOP;
               if_pc4_d   = 32'd0;
               if_valid_d = 1'b0;
               state_d    = REQ;
            end else if (!hold) begin
               if_instr_d = instr_buf_q;
               if_pc4_d   = pc_plus4;
               if_valid_d = 1'b1;
               pc_d       = pc_plus4;
               state_d    = REQ;
            end
         end
         DISCARD: begin
            if (flush) begin
               pc_d = target;
            end
            if (imem.imemValid) begin
               state_d = REQ;
            end
            if (flush || !hold) begin
               if_instr_d = NOP;
               if_pc4_d   = 32'd0;
               if_valid_d = 1'b0;
            end
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         instr_buf_q <= 32'd0;
         if_instr_q  <= NOP;
         if_pc4_q    <= 32'd0;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_buf_q <= instr_buf_d;
         if_instr_q  <= if_instr_d;
         if_pc4_q    <= if_pc4_d;
         if_valid_q  <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency imem model
module tb_fetch_unit;

   logic        clk;
   logic        rstn;
   logic        PcWrite;
   logic        IRWrite;
   logic        flush;
   logic        PcSrc;
   logic        Jmp;
   logic [31:0] branchTarget;
   logic [31:0] jmpTarget;
   logic [31:0] instrID;
   logic [31:0] pcPlus4ID;
   logic        validID;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP      (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .PcWrite      (PcWrite),
      .IRWrite      (IRWrite),
      .flush        (flush),
      .PcSrc        (PcSrc),
      .Jmp          (Jmp),
      .branchTarget (branchTarget),
      .jmpTarget    (jmpTarget),
      .imem         (bus),
      .instrID      (instrID),
      .pcPlus4ID    (pcPlus4ID),
      .validID      (validID)
   );

   int checks = 0;
   int errors = 0;
   int mem_lat = 1;
   logic [63:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   // Memory: samples the request in mid-cycle, answers mem_lat cycles later.
   logic        req_n;
   logic [31:0] addr_n;
   logic        pend;
   logic [31:0] paddr;
   int          cnt;
   initial begin
      bus.imemValid = 1'b0;
      bus.imemData  = 32'd0;
      pend = 1'b0;
      cnt = 0;
      paddr = 32'd0;
      forever begin
         @(negedge clk);
         req_n  = bus.imemReq;
         addr_n = bus.imemAddr;
         @(posedge clk);
         #1;
         bus.imemValid = 1'b0;
         if (!rstn) begin
            pend = 1'b0;
         end else begin
            if (req_n) begin
               pend  = 1'b1;
               cnt   = mem_lat;
               paddr = addr_n;
            end
            if (pend) begin
               cnt = cnt - 1;
               if (cnt == 0) begin
                  bus.imemValid = 1'b1;
                  bus.imemData  = mem_word(paddr);
                  pend = 1'b0;
               end
            end
         end
      end
   end

   // Scoreboard: every new valid IF/ID entry must match the head of exp_q.
   logic        prev_v;
   logic [31:0] prev_pc4;
   logic [63:0] exp_e;
   initial begin
      prev_v = 1'b0;
      prev_pc4 = 32'd0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_v = 1'b0;
         end else begin
            if (validID && (!prev_v || pcPlus4ID != prev_pc4)) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: got instr=%h pc4=%h, none expected", instrID, pcPlus4ID);
               end else begin
                  exp_e = exp_q.pop_front();
                  if ({instrID, pcPlus4ID} !== exp_e) begin
                     errors++;
                     $display("FAIL sb_entry: got instr=%h pc4=%h, need instr=%h pc4=%h",
                              instrID, pcPlus4ID, exp_e[63:32], exp_e[31:0]);
                  end
               end
            end
            prev_v   = validID;
            prev_pc4 = pcPlus4ID;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      PcWrite = 1'b1;
      IRWrite = 1'b1;
      flush = 1'b0;
      PcSrc = 1'b0;
      Jmp = 1'b0;
      branchTarget = 32'd0;
      jmpTarget = 32'd0;
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      mem_lat = 1;
      PcWrite = 1'b1; IRWrite = 1'b1; flush = 1'b0; PcSrc = 1'b0; Jmp = 1'b0;
      branchTarget = 32'd0; jmpTarget = 32'd0;
      rstn = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.imemReq !== 1'b0 || bus.imemAddr !== 32'd0) begin
         errors++;
         $display("FAIL rst_req: req=%b addr=%h, need req=0 addr=0", bus.imemReq, bus.imemAddr);
      end
      checks++;
      if (validID !== 1'b0 || instrID !== 32'd0 || pcPlus4ID !== 32'd0) begin
         errors++;
         $display("FAIL rst_ifid: v=%b i=%h p=%h, need 0/0/0", validID, instrID, pcPlus4ID);
      end
      tick();
      rstn = 1'b1;
      #1;
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'd0) begin
         errors++;
         $display("FAIL rst_first_req: req=%b addr=%h, need req=1 addr=0", bus.imemReq, bus.imemAddr);
      end
      exp_q.push_back({mem_word(32'd0), 32'd4});
      tick();
      tick();
      PcWrite = 1'b0;
      tick();
      // In WAIT with IF/ID still holding the first instruction.
      PcWrite = 1'b1;
      checks++;
      if (validID !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid: v=%b, need 1", validID);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0 || validID !== 1'b0 || instrID !== 32'd0 || bus.imemAddr !== 32'd0) begin
         errors++;
         $display("FAIL rst_async: req=%b v=%b i=%h addr=%h, need 0/0/0/0",
                  bus.imemReq, validID, instrID, bus.imemAddr);
      end
      tick();
      tick();
      rstn = 1'b1;
      #1;
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'd0) begin
         errors++;
         $display("FAIL rst_rerun_req: req=%b addr=%h, need req=1 addr=0", bus.imemReq, bus.imemAddr);
      end
      exp_q.push_back({mem_word(32'd0), 32'd4});
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rst_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_straight();
      mem_lat = 1;
      do_reset();
      exp_q.push_back({mem_word(32'd0), 32'd4});
      exp_q.push_back({mem_word(32'd4), 32'd8});
      exp_q.push_back({mem_word(32'd8), 32'd12});
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (validID !== ((k % 2) == 0)) begin
            errors++;
            $display("FAIL straight_v%0d: v=%b, need %b", k, validID, ((k % 2) == 0));
         end
      end
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL straight_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_hold();
      mem_lat = 1;
      do_reset();
      exp_q.push_back({mem_word(32'd0), 32'd4});
      exp_q.push_back({mem_word(32'd4), 32'd8});
      tick();
      tick();
      PcWrite = 1'b0; IRWrite = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.imemReq !== 1'b0 || validID !== 1'b1 || instrID !== mem_word(32'd0) || pcPlus4ID !== 32'd4) begin
         errors++;
         $display("FAIL hold_c3: req=%b v=%b i=%h p=%h, need 0/1/%h/4",
                  bus.imemReq, validID, instrID, pcPlus4ID, mem_word(32'd0));
      end
      tick();
      PcWrite = 1'b1; IRWrite = 1'b1;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0 || validID !== 1'b1 || pcPlus4ID !== 32'd4) begin
         errors++;
         $display("FAIL hold_c4: req=%b v=%b p=%h, need 0/1/4", bus.imemReq, validID, pcPlus4ID);
      end
      tick();
      #1;
      checks++;
      if (instrID !== mem_word(32'd4) || pcPlus4ID !== 32'd8 || validID !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: i=%h p=%h v=%b, need %h/8/1",
                  instrID, pcPlus4ID, validID, mem_word(32'd4));
      end
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'd8) begin
         errors++;
         $display("FAIL hold_next_req: req=%b addr=%h, need 1/8", bus.imemReq, bus.imemAddr);
      end
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL hold_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_jump_flush();
      mem_lat = 3;
      do_reset();
      tick();
      flush = 1'b1; Jmp = 1'b1; jmpTarget = 32'h40;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0) begin
         errors++;
         $display("FAIL jmp_req_flush: req=%b, need 0", bus.imemReq);
      end
      tick();
      flush = 1'b0; Jmp = 1'b0;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0 || validID !== 1'b0) begin
         errors++;
         $display("FAIL jmp_discard: req=%b v=%b, need 0/0", bus.imemReq, validID);
      end
      tick();
      tick();
      #1;
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h40 || validID !== 1'b0) begin
         errors++;
         $display("FAIL jmp_redirect: req=%b addr=%h v=%b, need 1/40/0", bus.imemReq, bus.imemAddr, validID);
      end
      exp_q.push_back({mem_word(32'h40), 32'h44});
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL jmp_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_branch_valid();
      mem_lat = 1;
      do_reset();
      tick();
      flush = 1'b1; PcSrc = 1'b1; branchTarget = 32'h100;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0) begin
         errors++;
         $display("FAIL br_req_flush: req=%b, need 0", bus.imemReq);
      end
      tick();
      flush = 1'b0; PcSrc = 1'b0;
      #1;
      checks++;
      if (validID !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100) begin
         errors++;
         $display("FAIL br_redirect: v=%b req=%b addr=%h, need 0/1/100", validID, bus.imemReq, bus.imemAddr);
      end
      exp_q.push_back({mem_word(32'h100), 32'h104});
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL br_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_double_flush();
      mem_lat = 3;
      do_reset();
      tick();
      flush = 1'b1; Jmp = 1'b1; jmpTarget = 32'h40;
      tick();
      jmpTarget = 32'h200;
      #1;
      checks++;
      if (bus.imemReq !== 1'b0) begin
         errors++;
         $display("FAIL dbl_req_discard: req=%b, need 0", bus.imemReq);
      end
      tick();
      flush = 1'b0; Jmp = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h200 || validID !== 1'b0) begin
         errors++;
         $display("FAIL dbl_redirect: req=%b addr=%h v=%b, need 1/200/0", bus.imemReq, bus.imemAddr, validID);
      end
      exp_q.push_back({mem_word(32'h200), 32'h204});
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL dbl_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      mem_lat = 1;
      do_reset();
      tick();
      flush = 1'b1; Jmp = 1'b1; jmpTarget = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0; Jmp = 1'b0;
      #1;
      checks++;
      if (bus.imemAddr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_addr: addr=%h, need fffffffc", bus.imemAddr);
      end
      exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'd0});
      tick();
      tick();
      #1;
      checks++;
      if (validID !== 1'b1 || pcPlus4ID !== 32'd0 || bus.imemAddr !== 32'd0 || bus.imemReq !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pc4: v=%b p=%h addr=%h req=%b, need 1/0/0/1",
                  validID, pcPlus4ID, bus.imemAddr, bus.imemReq);
      end
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_drain: %0d left, need 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_straight();
      test_hold();
      test_jump_flush();
      test_branch_valid();
      test_double_flush();
      test_wrap();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
